ssd_scan_decoder: RTL and testbench

//  Receiving end of the 4-digit multiplexed SSD drive (active-low anodes An3..An0, active-low cathodes Ca..Cg,Dp).

---
 rtl/ssd_pkg.sv | 51 +++++
 rtl/ssd_scan_decoder_pattern_decode.sv | 21 ++
 rtl/ssd_scan_decoder.sv | 176 +++++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the SSD scan decoder.
// Segment table is abcdefg, active-low, indexed by hex value.
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } state_t;

    typedef enum logic [1:0] {
        CLS_LEGAL,
        CLS_BLANK,
        CLS_ILLEGAL
    } an_class_t;

    localparam logic [3:0] AN_D0    = 4'b1110;
    localparam logic [3:0] AN_D1    = 4'b1101;
    localparam logic [3:0] AN_D2    = 4'b1011;
    localparam logic [3:0] AN_D3    = 4'b0111;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    function automatic an_class_t an_class(input logic [3:0] an);
        an_class_t c;
        case (an)
            AN_D0, AN_D1, AN_D2, AN_D3: c = CLS_LEGAL;
            AN_BLANK:                   c = CLS_BLANK;
            default:                    c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            AN_D1:   idx = 2'd1;
            AN_D2:   idx = 2'd2;
            AN_D3:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ssd_scan_decoder_pattern_decode.sv
// Combinational 7-segment pattern to hex value lookup.
module ssd_pattern_decode
    import ssd_pkg::*;
(
    input  logic [6:0] i_segs,
    output logic       o_hit,
    output logic [3:0] o_value
);

    always_comb begin
        o_hit   = 1'b0;
        o_value = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (i_segs == SEG_TABLE[k]) begin
                o_hit   = 1'b1;
                o_value = 4'(k);
            end
        end
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Monitors a multiplexed 4-digit SSD drive and rebuilds the shown digits.
// Define SSD_DP_CAPTURE_EN to also capture the dot point per digit.
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int N_STABLE  = 16,
    parameter int TIMEOUT_W = 22
) (
    input  logic        board_clk,
    input  logic        Reset,
    input  logic [3:0]  An,
    input  logic [7:0]  Cathodes,
    output logic [15:0] Digits,
    output logic [3:0]  DigitValid,
    output logic [3:0]  DpOut,
    output logic        FrameDone,
    output logic        DecodeErr,
    output logic        Stalled
);

    localparam int CNT_W = $clog2(N_STABLE + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(N_STABLE);

    logic [3:0]           r_an, r_an_p;
    logic [7:0]           r_ca, r_ca_p;
    state_t               r_state, w_state_n;
    logic [CNT_W-1:0]     r_cnt, w_cnt_n;
    logic [TIMEOUT_W-1:0] r_stall;
    logic [15:0]          r_digits;
    logic [3:0]           r_valid, r_mask;
    logic                 r_frame, r_err;
    logic                 w_chg, w_decode, w_ill_err;
    logic                 w_hit;
    logic [3:0]           w_value, w_mask_n;
    logic [1:0]           w_idx;
    an_class_t            w_cls;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_an   <= AN_BLANK;
            r_an_p <= AN_BLANK;
            r_ca   <= 8'hFF;
            r_ca_p <= 8'hFF;
        end else begin
            r_an   <= An;
            r_an_p <= r_an;
            r_ca   <= Cathodes;
            r_ca_p <= r_ca;
        end
    end

    assign w_chg    = {r_an, r_ca} != {r_an_p, r_ca_p};
    assign w_cls    = an_class(r_an);
    assign w_idx    = an_index(r_an);
    assign w_mask_n = r_mask | (4'b0001 << w_idx);

    ssd_pattern_decode u_dec (
        .i_segs  (r_ca[7:1]),
        .o_hit   (w_hit),
        .o_value (w_value)
    );

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // IDLE also times illegal anodes so a held bad pattern errors once
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_decode  = 1'b0;
        w_ill_err = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cls == CLS_LEGAL) begin
                    w_state_n = SETTLE;
                    w_cnt_n   = CNT_ONE;
                end else if (w_cls == CLS_BLANK) begin
                    w_cnt_n = '0;
                end else if (w_chg) begin
                    w_cnt_n = CNT_ONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_ill_err = 1'b1;
                    w_cnt_n   = CNT_SAT;
                end else if (r_cnt != CNT_SAT) begin
                    w_cnt_n = r_cnt + CNT_ONE;
                end
            end
            SETTLE, CAPTURED: begin
                if (w_chg) begin
                    w_state_n = (w_cls == CLS_LEGAL) ? SETTLE : IDLE;
                    w_cnt_n   = (w_cls == CLS_BLANK) ? '0 : CNT_ONE;
                end else if (r_state == SETTLE) begin
                    if (r_cnt == CNT_LAST) begin
                        w_decode  = 1'b1;
                        w_state_n = CAPTURED;
                    end else begin
                        w_cnt_n = r_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_digits <= '0;
            r_valid  <= '0;
            r_mask   <= '0;
            r_frame  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            r_err   <= w_ill_err | (w_decode & ~w_hit);
            if (w_decode) begin
                if (w_hit) begin
                    r_digits[{w_idx, 2'b00} +: 4] <= w_value;
                    r_valid[w_idx]                <= 1'b1;
                    if (w_mask_n == 4'hF) begin
                        r_frame <= 1'b1;
                        r_mask  <= '0;
                    end else begin
                        r_mask <= w_mask_n;
                    end
                end else begin
                    r_valid[w_idx] <= 1'b0;
                end
            end
        end
    end

`ifdef SSD_DP_CAPTURE_EN
    logic [3:0] r_dp;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_dp <= '0;
        end else if (w_decode && w_hit) begin
            r_dp[w_idx] <= ~r_ca[0];
        end
    end

    assign DpOut = r_dp;
`else
    assign DpOut = 4'b0000;
`endif

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_stall <= '0;
        end else if (r_an != r_an_p) begin
            r_stall <= '0;
        end else if (!(&r_stall)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign Digits     = r_digits;
    assign DigitValid = r_valid;
    assign FrameDone  = r_frame;
    assign DecodeErr  = r_err;
    assign Stalled    = &r_stall;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Self-checking bench for ssd_scan_decoder: directed cases plus random
// scan steps checked against a digit-level reference model.
module tb_ssd_scan_decoder;

    localparam int LONG = 20;

    logic        board_clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  An = 4'hF;
    logic [7:0]  Cathodes = 8'hFF;
    logic [15:0] Digits;
    logic [3:0]  DigitValid, DpOut;
    logic        FrameDone, DecodeErr, Stalled;

    int n_assert = 0;
    int n_fail   = 0;
    int n_frames = 0;
    int n_errs   = 0;

    logic [3:0] m_dig [4];
    logic [3:0] m_val, m_mask, m_dp;
    int         m_frames, m_errs;

    logic [6:0] seg_of [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    always #5 board_clk = ~board_clk;

    ssd_scan_decoder #(.N_STABLE(16), .TIMEOUT_W(8)) dut (
        .board_clk  (board_clk),
        .Reset      (Reset),
        .An         (An),
        .Cathodes   (Cathodes),
        .Digits     (Digits),
        .DigitValid (DigitValid),
        .DpOut      (DpOut),
        .FrameDone  (FrameDone),
        .DecodeErr  (DecodeErr),
        .Stalled    (Stalled)
    );

    always @(posedge board_clk) begin
        if (FrameDone === 1'b1) n_frames++;
        if (DecodeErr === 1'b1) n_errs++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
        m_val  = 4'h0;
        m_mask = 4'h0;
        m_dp   = 4'h0;
    endtask

    task automatic model_step(input logic [3:0] an, input logic [7:0] ca,
                              input int hold);
        int idx;
        int v;
        logic [3:0] oh;
        idx = -1;
        v   = -1;
        if (hold < LONG) return;
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            if (an == ~oh) idx = k;
        end
        if (idx < 0) begin
            if (an != 4'hF) m_errs++;
            return;
        end
        for (int k = 0; k < 16; k++)
            if (seg_of[k] == ca[7:1]) v = k;
        if (v >= 0) begin
            m_dig[idx]  = v[3:0];
            m_val[idx]  = 1'b1;
            m_mask[idx] = 1'b1;
            if (m_mask == 4'hF) begin
                m_frames++;
                m_mask = 4'h0;
            end
`ifdef SSD_DP_CAPTURE_EN
            m_dp[idx] = ~ca[0];
`endif
        end else begin
            m_val[idx] = 1'b0;
            m_errs++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".digits"}, 32'(Digits),
            32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        chk({tag, ".valid"}, 32'(DigitValid), 32'(m_val));
        chk({tag, ".dp"}, 32'(DpOut), 32'(m_dp));
        chk({tag, ".frames"}, 32'(n_frames), 32'(m_frames));
        chk({tag, ".errs"}, 32'(n_errs), 32'(m_errs));
    endtask

    task automatic step(input string tag, input logic [3:0] an,
                        input logic [7:0] ca, input int hold, input int gap);
        An       = an;
        Cathodes = ca;
        repeat (hold) @(negedge board_clk);
        if (gap > 0) begin
            An       = 4'hF;
            Cathodes = 8'hFF;
            repeat (gap) @(negedge board_clk);
        end
        model_step(an, ca, hold);
        check_all(tag);
    endtask

    initial begin
        logic [3:0] an;
        logic [7:0] ca;
        int         r, hold;
        m_frames = 0;
        m_errs   = 0;
        model_reset();

        repeat (3) @(negedge board_clk);
        check_all("reset");
        chk("reset.stalled", 32'(Stalled), 32'd0);
        Reset = 1'b0;
        repeat (2) @(negedge board_clk);

        step("t1", 4'b1110, 8'b00001100, 20, 3);
        chk("t1.nibble0", 32'(Digits[3:0]), 32'h3);

        step("t2.d0", 4'b1110, {seg_of[5], 1'b1}, 100, 0);
        step("t2.d1", 4'b1101, {seg_of[10], 1'b1}, 100, 0);
        step("t2.d2", 4'b1011, {seg_of[3], 1'b1}, 100, 0);
        chk("t2.noframe", 32'(n_frames), 32'd0);
        step("t2.d3", 4'b0111, {seg_of[15], 1'b1}, 100, 3);
        chk("t2.digits", 32'(Digits), 32'hF3A5);
        chk("t2.frame", 32'(n_frames), 32'd1);

        step("t3", 4'b1101, 8'b11111110, 20, 3);
        chk("t3.valid1", 32'(DigitValid[1]), 32'd0);
        chk("t3.nibble1", 32'(Digits[7:4]), 32'hA);

        step("t4.ill", 4'b1100, {seg_of[8], 1'b1}, 20, 3);
        chk("t4.err", 32'(n_errs), 32'd2);
        for (int k = 0; k < 6; k++)
            step("t4.tog", (k % 2 == 0) ? 4'b1110 : 4'b1101,
                 {seg_of[k], 1'b1}, 10, (k == 5) ? 3 : 0);

        for (int s = 0; s < 40; s++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) an = ~(4'b0001 << $urandom_range(0, 3));
            else if (r < 85) an = 4'($urandom_range(0, 15));
            else an = 4'hF;
            if ($urandom_range(0, 4) != 0)
                ca = {seg_of[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
            else
                ca = 8'($urandom);
            hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 30))
                                               : int'($urandom_range(3, 12));
            step("rand", an, ca, hold, 3);
        end

        An       = 4'b1011;
        Cathodes = {seg_of[7], 1'b1};
        repeat (200) @(negedge board_clk);
        chk("t5.notyet", 32'(Stalled), 32'd0);
        repeat (100) @(negedge board_clk);
        chk("t5.stalled", 32'(Stalled), 32'd1);
        model_step(4'b1011, {seg_of[7], 1'b1}, 300);
        An       = 4'hF;
        Cathodes = 8'hFF;
        repeat (2) @(negedge board_clk);
        chk("t5.cleared", 32'(Stalled), 32'd0);
        check_all("t5");

        An       = 4'b1011;
        Cathodes = {seg_of[2], 1'b0};
        repeat (10) @(negedge board_clk);
        Reset = 1'b1;
        #2;
        model_reset();
        chk("t6.rst.digits", 32'(Digits), 32'd0);
        chk("t6.rst.valid", 32'(DigitValid), 32'd0);
        chk("t6.rst.dp", 32'(DpOut), 32'd0);
        chk("t6.rst.pulses", 32'({FrameDone, DecodeErr, Stalled}), 32'd0);
        @(negedge board_clk);
        Reset = 1'b0;
        step("t6", 4'b1011, {seg_of[2], 1'b0}, 20, 3);
`ifdef SSD_DP_CAPTURE_EN
        chk("t6.dpout", 32'(DpOut), 32'b0100);
`else
        chk("t6.dpout", 32'(DpOut), 32'b0000);
`endif
        chk("t6.nibble2", 32'(Digits[11:8]), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
